dsp_cic_comp_fir: RTL and testbench
===================================

// Module: dsp_cic_comp_fir
// PURPOSE
//   Serial-MAC CIC droop-compensation FIR. Sits directly downstream of dsp_cic_dec_var
//   and consumes its truncated output (dout_cut/dout_vld). One multiplier is time-shared
//   over TAPS cycles per input sample, so the input sample rate must be <= clk/(TAPS+1).
//   Output is rounded, saturated, and strobed with a one-cycle valid pulse.
// PARAMETERS
//   BIN   16                          input sample width, signed
//   BOUT  16                          output sample width, signed
//   CW    16                          coefficient width, signed
//   TAPS  5                           number of taps, 1..32
//   SHIFT 15                          right shift applied to the accumulator before output
//   COEF  {-1024,4096,26624,4096,-1024} packed CW*TAPS bits; tap k = COEF[CW*k +: CW]
//                                     (default sums to 32768 = unity DC gain at SHIFT=15)
// PORTS
//   clk       in   1     clock, the CIC fs clock
//   rst       in   1     asynchronous, active-high reset
//   din       in   BIN   signed input sample (from CIC dout_cut)
//   din_vld   in   1     input strobe, one cycle per sample (from CIC dout_vld)
//   dout      out  BOUT  signed filtered sample, held between strobes
//   dout_vld  out  1     one-cycle output strobe
//   busy      out  1     high while a MAC pass is in progress; a strobe arriving now is dropped
//   sat       out  1     high alongside dout_vld when the current output was clipped
//   drop      out  1     sticky; set when din_vld arrives while busy; cleared only by rst
// BEHAVIOUR
//   Reset (async, rst=1): dout=0, dout_vld=0, busy=0, sat=0, drop=0, state=IDLE,
//     delay line all zero, write pointer=0, accumulator=0. Asserting rst mid-pass aborts the
//     pass immediately. No output is produced for the aborted sample.
//   Delay line: TAPS-entry circular buffer. x[0] is the newest sample.
//     y = sum_k COEF_k * x[k], with k=0 applied to the newest sample.
//   Accumulator width: BIN+CW+$clog2(TAPS)+1, signed. Products are full precision.
//   FSM:
//     IDLE: busy=0. On din_vld, write din at wptr, set wptr=wptr+1 (wraps TAPS-1 -> 0),
//       clear acc, set k=0, go to MAC.
//     MAC: busy=1. Each cycle acc += COEF_k * x[k] and k++.
//       After k=TAPS-1 is accumulated, go to OUT.
//     OUT: busy=0. Registered dout is updated and dout_vld=1 for exactly this cycle.
//       A din_vld seen in OUT is accepted, following the IDLE rules, and the FSM goes to MAC.
//       With no din_vld, the FSM goes to IDLE.
//   Latency: din_vld sampled at edge 0 -> dout_vld high during cycle TAPS+1.
//     Back-to-back throughput is one sample per TAPS+1 cycles.
//   Rounding: r = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
//     With SHIFT=0 there is no add.
//   Saturation: if r > 2^(BOUT-1)-1, dout = 2^(BOUT-1)-1.
//     If r < -2^(BOUT-1), dout = -2^(BOUT-1).
//     sat=1 in the dout_vld cycle if clipping occurred, otherwise 0. sat is 0 when dout_vld=0.
//   Overrun: din_vld while in MAC is ignored. The delay line and pass are unaffected and drop is set.
//   dout holds its last value until the next OUT cycle.
// TESTING
//   1 Reset: rst high with din_vld toggling -> all outputs 0. Then release rst, strobe one sample
//     -> dout_vld occurs exactly 6 clk after the strobe edge (TAPS=5).
//   2 Impulse, defaults: strobe din=1000 then 0,0,0,0 every 8 clk
//     -> dout = -31, 125, 813, 125, -31; sat=0.
//   3 DC, defaults: din=1000 held for 10 strobes -> dout settles to 1000 from the 5th output on.
//     din=-32768 held -> dout=-32768, sat=0.
//   4 Saturation, SHIFT=14 (gain 2): din=20000 held -> steady dout=32767, sat=1.
//     din=-20000 held -> dout=-32768, sat=1.
//   5 Rate/overrun: strobe every 6 clk -> every sample is output and drop stays 0.
//     Strobe 3 clk after an accepted strobe -> that sample is ignored, drop=1 and stays 1;
//     output matches the sequence with that sample removed.
//   6 Abort: assert rst 2 clk into MAC -> no dout_vld for that sample.
//     Next impulse response equals test 2 (delay line was cleared).
//   7 Chain: drive with dsp_cic_dec_var (dec_fac=100, CUT_METHOD ROUND) fed by a sine
//     -> every CIC dout_vld is accepted, drop=0, and the output matches the MATLAB golden model bit-exactly.

Source files
------------

// File: rtl/dsp_cic_comp_fir.sv
// dsp_cic_comp_fir
//   Serial-MAC CIC droop-compensation FIR. One multiplier is shared across
//   all taps, so a full pass takes TAPS cycles plus one output cycle. The
//   input sample rate must not exceed clk/(TAPS+1).
//   The output is rounded (half toward +inf), saturated to BOUT bits and
//   strobed with a one-cycle valid pulse.
// Ports
//   clk       clock (CIC fs clock)
//   rst       asynchronous, active-high reset; aborts a pass in progress
//   din       signed input sample
//   din_vld   input strobe, one cycle per sample
//   dout      signed filtered sample, held between strobes
//   dout_vld  one-cycle output strobe
//   busy      high while a MAC pass runs; a strobe arriving then is dropped
//   sat       high with dout_vld when the output was clipped
//   drop      sticky overrun flag, cleared only by rst
module dsp_cic_comp_fir #(
  parameter int BIN   = 16,
  parameter int BOUT  = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 5,
  parameter int SHIFT = 15,
  parameter logic [CW*TAPS-1:0] COEF = {16'hFC00, 16'h1000, 16'h6800, 16'h1000, 16'hFC00}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BIN-1:0]  din,
  input  logic            din_vld,
  output logic [BOUT-1:0] dout,
  output logic            dout_vld,
  output logic            busy,
  output logic            sat,
  output logic            drop
);

  localparam int AW = BIN + CW + $clog2(TAPS) + 1;
  localparam int PW = BIN + CW;
  localparam int RW = AW + 1;  // one guard bit so the rounding add cannot wrap
  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(TAPS - 1);
  localparam logic [RW-1:0] RND =
    (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] MAXV = {{(RW-BOUT+1){1'b0}}, {(BOUT-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-BOUT+1){1'b1}}, {(BOUT-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state, state_nxt;
  logic [BIN-1:0]         xbuf [TAPS];
  logic [KW-1:0]          wptr, rptr, k;
  logic signed [AW-1:0]   acc, acc_sum;
  logic signed [CW-1:0]   coef_k;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [RW-1:0]   rnd_sum, r;
  logic [BOUT-1:0]        dout_c;
  logic                   sat_c;
  logic                   accept;

  function automatic logic [KW-1:0] ptr_inc(input logic [KW-1:0] p);
    return (p == KLAST) ? '0 : p + KW'(1);
  endfunction

  function automatic logic [KW-1:0] ptr_dec(input logic [KW-1:0] p);
    return (p == '0) ? KLAST : p - KW'(1);
  endfunction

  // A strobe is taken in IDLE and also in OUT, which gives back-to-back
  // throughput of one sample per TAPS+1 cycles.
  assign accept = din_vld && (state != MAC);
  assign busy   = (state == MAC);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (din_vld) state_nxt = MAC;
      MAC:     if (k == KLAST) state_nxt = OUT;
      OUT:     state_nxt = din_vld ? MAC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rptr walks backwards from the newest sample, so tap k meets x[k].
  always_comb begin
    coef_k   = COEF[CW*int'(k) +: CW];
    prod     = coef_k * $signed(xbuf[rptr]);
    prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    acc_sum  = acc + prod_ext;
    rnd_sum  = {acc_sum[AW-1], acc_sum} + RND;
    r        = rnd_sum >>> SHIFT;
    sat_c    = 1'b0;
    dout_c   = r[BOUT-1:0];
    if (r > MAXV) begin
      sat_c  = 1'b1;
      dout_c = MAXV[BOUT-1:0];
    end else if (r < MINV) begin
      sat_c  = 1'b1;
      dout_c = MINV[BOUT-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      k        <= '0;
      acc      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      sat      <= 1'b0;
      drop     <= 1'b0;
      for (int i = 0; i < TAPS; i++) xbuf[i] <= '0;
    end else begin
      state    <= state_nxt;
      dout_vld <= 1'b0;
      sat      <= 1'b0;
      if (din_vld && state == MAC) drop <= 1'b1;
      if (accept) begin
        xbuf[wptr] <= din;
        rptr       <= wptr;
        wptr       <= ptr_inc(wptr);
        acc        <= '0;
        k          <= '0;
      end else if (state == MAC) begin
        acc  <= acc_sum;
        k    <= k + KW'(1);
        rptr <= ptr_dec(rptr);
        // Last tap: the result register loads on the edge entering OUT,
        // so dout_vld is high exactly while the FSM sits in OUT.
        if (k == KLAST) begin
          dout     <= dout_c;
          dout_vld <= 1'b1;
          sat      <= sat_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_cic_comp_fir.sv
// Directed bench for dsp_cic_comp_fir: default build (SHIFT=15) plus a
// SHIFT=14 build sharing the same inputs for the clipping cases.
module tb_dsp_cic_comp_fir;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        din_vld = 1'b0;

  logic [15:0] dout, dout14;
  logic        dout_vld, busy, sat, drop;
  logic        dout_vld14, busy14, sat14, drop14;

  int n_chk  = 0;
  int n_pass = 0;

  // captured by send()
  int   lat;
  int   y, y14;
  logic s, s14;

  always #5 clk = ~clk;

  dsp_cic_comp_fir u_dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
    .dout(dout), .dout_vld(dout_vld), .busy(busy), .sat(sat), .drop(drop)
  );

  dsp_cic_comp_fir #(.SHIFT(14)) u_dut14 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
    .dout(dout14), .dout_vld(dout_vld14), .busy(busy14), .sat(sat14), .drop(drop14)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Strobe one sample, then spend `period` clocks watching for the output.
  // Returns on the negedge from which the next strobe is sampled exactly
  // `period` clocks after this one. ovr_c>0 injects an extra strobe
  // (value 30000) that many clocks after the accepted one.
  task automatic send(input int v, input int period, input int ovr_c = 0);
    din     = 16'(v);
    din_vld = 1'b1;
    lat = -1; y = 99999; y14 = 99999; s = 1'bx; s14 = 1'bx;
    for (int c = 1; c <= period; c++) begin
      @(negedge clk);
      if (c == 1) din_vld = 1'b0;
      if (ovr_c > 0 && c == ovr_c) begin
        din     = 16'(30000);
        din_vld = 1'b1;
      end
      if (ovr_c > 0 && c == ovr_c + 1) din_vld = 1'b0;
      if (dout_vld && lat < 0) begin
        lat = c;
        y   = int'($signed(dout));
        s   = sat;
        y14 = int'($signed(dout14));
        s14 = sat14;
      end
    end
  endtask

  int imp[5]  = '{-31, 125, 813, 125, -31};
  int dc[10]  = '{-31, 94, 906, 1031, 1000, 1000, 1000, 1000, 1000, 1000};
  logic seen;

  initial begin
    // 1: reset holds everything at zero even with strobes toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din     = 16'd1234;
      din_vld = ~din_vld;
    end
    @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat, 0);
    chk("rst_drop", drop, 0);
    din_vld = 1'b0;
    rst     = 1'b0;
    @(negedge clk);

    // 1/2: impulse 1000 then zeros, 8 clk apart; first output also gives latency
    send(1000, 8);
    chk("latency", lat, 6);
    chk("imp0", y, imp[0]);
    chk("imp0_sat", s, 0);
    for (int i = 1; i < 5; i++) begin
      send(0, 8);
      chk($sformatf("imp%0d", i), y, imp[i]);
    end
    chk("dout_hold", int'($signed(dout)), -31);
    chk("vld_idle", dout_vld, 0);

    // 3: DC at the maximum rate; the old impulse sample is pushed out first
    for (int i = 0; i < 10; i++) begin
      send(1000, 6);
      chk($sformatf("dc%0d", i), y, dc[i]);
    end
    chk("dc_drop", drop, 0);
    for (int i = 0; i < 5; i++) begin
      send(-32768, 6);
      if (i == 0) chk("neg_edge", y, 2055);
    end
    chk("neg_full", y, -32768);
    chk("neg_full_sat", s, 0);

    // 4: gain-2 build clips both ways; unity build does not
    for (int i = 0; i < 5; i++) send(20000, 6);
    chk("pos_clip", y14, 32767);
    chk("pos_clip_sat", s14, 1);
    chk("pos_unity", y, 20000);
    chk("pos_unity_sat", s, 0);
    for (int i = 0; i < 5; i++) send(-20000, 6);
    chk("neg_clip", y14, -32768);
    chk("neg_clip_sat", s14, 1);
    chk("neg_unity", y, -20000);
    @(negedge clk);
    chk("sat_idle", sat14, 0);

    // 5: overrun 3 clk after an accepted strobe is ignored, drop sticks
    for (int i = 0; i < 5; i++) send(0, 6);
    send(1000, 6, 3);
    chk("ovr_lat", lat, 6);
    chk("ovr_y0", y, -31);
    chk("ovr_drop", drop, 1);
    send(2000, 6);
    chk("ovr_y1", y, 63);
    send(0, 6);
    chk("ovr_y2", y, 1063);
    chk("ovr_drop_sticky", drop, 1);

    // 6: reset two clocks into MAC aborts the pass and clears the line
    @(negedge clk);
    din     = 16'd1000;
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 1);
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dout_vld) seen = 1'b1;
    end
    chk("abort_novld", seen, 0);
    chk("abort_busy_clr", busy, 0);
    chk("abort_drop_clr", drop, 0);
    chk("abort_dout_clr", dout, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? 1000 : 0, 8);
      chk($sformatf("post_abort%0d", i), y, imp[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
